const_reg_bank: RTL and testbench
=================================

Name: const_reg_bank

Overview:
- Bank of NUM_K constant registers, each BYTES×DATA_W bits wide, loaded over a narrow DATA_W-bit bus.
- Loads are either sequential (LSB-first, auto-incrementing byte pointer, committed atomically with optional sign/zero extension) or direct (a single byte patched in place).
- Sits between the instruction/operand fetch path and the datapath; the datapath reads constants through a zero-latency read mux.

Parameters:
- DATA_W, 8, bus/byte width in bits.
- BYTES, 2, bytes per constant register (≥2); register width KW = BYTES*DATA_W.
- NUM_K, 4, number of constant registers (≥2); SEL_W = clog2(NUM_K), PTR_W = clog2(BYTES+1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- k_in  in  DATA_W  byte data for sequential and direct writes.
- load_start  in  1  begin sequential load into register load_sel.
- load_sel  in  SEL_W  target register; sampled only with load_start.
- load_byte  in  1  write k_in at the current pointer.
- load_last  in  1  commit on this byte; qualified by load_byte.
- sext  in  1  sampled with load_start: 1 = sign-extend, 0 = zero-extend.
- dir_we  in  1  direct byte write into a committed register.
- dir_sel  in  SEL_W  direct-write register index.
- dir_byte  in  clog2(BYTES)  direct-write byte lane.
- rd_sel  in  SEL_W  read select.
- k_out  out  KW  contents of register rd_sel (combinational mux of registers).
- k_valid  out  NUM_K  per-register "committed since reset" flag.
- busy  out  1  sequential load in progress.
- commit  out  1  one-cycle pulse in the cycle after a commit edge.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (async): all registers 0, k_valid 0, busy 0, commit 0, err 0, pointer 0, shadow 0.
- State machine IDLE/LOAD, with busy = (state == LOAD).
- IDLE, load_start: go to LOAD. Latch tgt = load_sel and ext = sext, set ptr = 0, shadow = 0, clear err.
- LOAD, load_start: abort the current load with no commit and restart as above; err is cleared.
- LOAD, load_byte, ptr < BYTES: shadow lane ptr ← k_in, ptr ← ptr+1.
- LOAD, load_byte, ptr == BYTES: byte dropped, err ← 1, stay in LOAD.
  - If load_last is also high, commit the existing shadow (n = BYTES).
- LOAD, load_byte & load_last: commit on this edge, go to IDLE, ptr ← 0.
  - n = number of bytes written including this one.
  - Lanes 0..n-1 come from the shadow merged with the current byte.
  - Lanes n..BYTES-1 are filled with 0 (ext = 0) or replicate bit DATA_W-1 of lane n-1 (ext = 1).
  - Write the result to reg[tgt]; set k_valid[tgt]; commit = 1 in the next cycle only.
- load_last without load_byte: ignored.
- load_byte in IDLE: ignored, err ← 1.
- Priority per edge: reset > load_start > load_byte.
  - load_start and load_byte together: start wins, and the byte is not written.
- Direct write: dir_we sets reg[dir_sel] lane dir_byte ← k_in. Other lanes and k_valid are unchanged.
  - Legal in any state.
  - If it targets the same register as a same-cycle commit, the commit wins and the direct byte is lost.
  - Different registers update independently in the same cycle.
- k_out = reg[rd_sel], combinational. A commit is visible on k_out in the cycle after the commit edge.
- The shadow is invisible: k_out shows the old value throughout a LOAD.
- An out-of-range dir_sel/rd_sel (NUM_K not a power of two) is ignored on write and reads as 0.
- err is cleared only by reset or load_start.

Test Plan (DATA_W=8, BYTES=2, NUM_K=4):
- Reset mid-LOAD after one byte → all k_out 0, k_valid=0000, busy=0, err=0 immediately (async, no clock edge).
- load_start(sel=2, sext=0); byte 0x34; byte 0x12 with load_last → reg2=0x1234, k_valid=0100, commit pulses one cycle, busy falls.
- load_start(sel=1, sext=1); byte 0x85 with load_last → reg1=0xFF85. Repeat with sext=0 → 0x0085; with byte 0x05 and sext=1 → 0x0005.
- Load reg3 = 0xBEEF; then dir_we (sel=3, byte=1, k_in=0x12) → reg3=0x12EF. dir_we in the same cycle as a commit to reg3 → the commit value wins.
- Bytes 0x11, 0x22, then a third byte 0x33 (ptr full) → err=1, byte dropped. Next byte with load_last commits 0x2211. Next load_start clears err. load_byte in IDLE sets err.
- Byte 0xAA, then load_start(sel=0) → no commit, reg unchanged. Then 0x01, 0x02+last → reg0=0x0201. load_start with load_byte in the same cycle → byte not written, ptr=0.

Source files
------------

// File: rtl/const_reg_bank_if.sv
// Bus bundle for const_reg_bank: load/direct-write controls in, constant read path and status out.
interface const_reg_bank_if #(
   parameter int DATA_W = 8,
   parameter int BYTES  = 2,
   parameter int NUM_K  = 4
);
   localparam int KW    = BYTES * DATA_W;
   localparam int SEL_W = $clog2(NUM_K);
   localparam int LN_W  = $clog2(BYTES);

   // Handshake: there is no ready; the bank accepts every qualified strobe on the edge it
   // is seen. load_byte qualifies k_in and load_last; load_start qualifies load_sel and
   // sext; dir_we qualifies dir_sel, dir_byte and k_in. Unqualified fields are don't-care.
   logic [DATA_W-1:0] k_in;
   logic              load_start;
   logic [SEL_W-1:0]  load_sel;
   logic              load_byte;
   logic              load_last;
   logic              sext;
   logic              dir_we;
   logic [SEL_W-1:0]  dir_sel;
   logic [LN_W-1:0]   dir_byte;
   logic [SEL_W-1:0]  rd_sel;
   logic [KW-1:0]     k_out;
   logic [NUM_K-1:0]  k_valid;
   logic              busy;
   logic              commit;
   logic              err;
   logic              state_dbg;

   modport master (
      output k_in, load_start, load_sel, load_byte, load_last, sext,
             dir_we, dir_sel, dir_byte, rd_sel,
      input  k_out, k_valid, busy, commit, err, state_dbg
   );

   modport slave (
      input  k_in, load_start, load_sel, load_byte, load_last, sext,
             dir_we, dir_sel, dir_byte, rd_sel,
      output k_out, k_valid, busy, commit, err, state_dbg
   );
endinterface

// File: rtl/const_reg_bank.sv
// Constant register bank: bytes are staged LSB-first in a shadow and committed atomically
// (with optional sign/zero extension), or patched one lane at a time by direct writes.
module const_reg_bank #(
   parameter int DATA_W = 8,
   parameter int BYTES  = 2,
   parameter int NUM_K  = 4
) (
   input logic            clk,
   input logic            reset,
   const_reg_bank_if.slave bus
);
   localparam int KW    = BYTES * DATA_W;
   localparam int SEL_W = $clog2(NUM_K);
   localparam int PTR_W = $clog2(BYTES + 1);

   typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [KW-1:0]      k_reg [NUM_K];
   logic [NUM_K-1:0]   k_valid_q;
   logic [KW-1:0]      shadow_q;
   logic [PTR_W-1:0]   ptr_q;
   logic [SEL_W-1:0]   tgt_q;
   logic               ext_q;
   logic               err_q;
   logic               commit_q;

   // per-edge strobes decoded by the FSM
   logic               start_now;
   logic               wr_now;
   logic               drop_now;
   logic               commit_now;
   logic               idle_err;

   logic [KW-1:0]      merged;
   logic [KW-1:0]      commit_val;
   logic               sign_bit;
   int                 n_bytes;
   logic               dir_ok;

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state and strobes; load_start outranks load_byte on the same edge
   always_comb begin
      state_d    = state_q;
      start_now  = 1'b0;
      wr_now     = 1'b0;
      drop_now   = 1'b0;
      commit_now = 1'b0;
      idle_err   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.load_start) begin
               start_now = 1'b1;
               state_d   = LOAD;
            end else if (bus.load_byte) begin
               idle_err = 1'b1;
            end
         end
         LOAD: begin
            if (bus.load_start) begin
               start_now = 1'b1;
            end else if (bus.load_byte) begin
               if (int'(ptr_q) < BYTES) wr_now   = 1'b1;
               else                     drop_now = 1'b1;
               if (bus.load_last) begin
                  commit_now = 1'b1;
                  state_d    = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Shadow merged with the current byte, then extended above the last written lane
   always_comb begin
      merged     = shadow_q;
      n_bytes    = BYTES;
      sign_bit   = 1'b0;
      commit_val = '0;
      if (wr_now) begin
         for (int i = 0; i < BYTES; i++)
            if (i == int'(ptr_q)) merged[i*DATA_W +: DATA_W] = bus.k_in;
         n_bytes = int'(ptr_q) + 1;
      end
      for (int i = 0; i < BYTES; i++)
         if (i == n_bytes - 1) sign_bit = merged[i*DATA_W + DATA_W - 1];
      for (int i = 0; i < BYTES; i++) begin
         if (i < n_bytes)  commit_val[i*DATA_W +: DATA_W] = merged[i*DATA_W +: DATA_W];
         else if (ext_q)   commit_val[i*DATA_W +: DATA_W] = {DATA_W{sign_bit}};
         else              commit_val[i*DATA_W +: DATA_W] = '0;
      end
   end

   // Load bookkeeping: pointer, shadow, latched target/extension, sticky error, commit pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_q <= '0;
         ptr_q    <= '0;
         tgt_q    <= '0;
         ext_q    <= 1'b0;
         err_q    <= 1'b0;
         commit_q <= 1'b0;
      end else begin
         commit_q <= commit_now;
         if (start_now) begin
            tgt_q    <= bus.load_sel;
            ext_q    <= bus.sext;
            ptr_q    <= '0;
            shadow_q <= '0;
            err_q    <= 1'b0;
         end else begin
            if (wr_now) begin
               shadow_q <= merged;
               ptr_q    <= ptr_q + 1'b1;
            end
            if (drop_now || idle_err) err_q <= 1'b1;
            if (commit_now) ptr_q <= '0;
         end
      end
   end

   // Direct writes are dropped when the index or lane does not exist
   always_comb begin
      dir_ok = bus.dir_we && (int'(bus.dir_sel) < NUM_K) && (int'(bus.dir_byte) < BYTES);
   end

   // Register bank: a commit beats a direct write to the same register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_K; i++) k_reg[i] <= '0;
         k_valid_q <= '0;
      end else begin
         for (int i = 0; i < NUM_K; i++) begin
            if (commit_now && int'(tgt_q) == i) begin
               k_reg[i]     <= commit_val;
               k_valid_q[i] <= 1'b1;
            end else if (dir_ok && int'(bus.dir_sel) == i) begin
               for (int b = 0; b < BYTES; b++)
                  if (int'(bus.dir_byte) == b) k_reg[i][b*DATA_W +: DATA_W] <= bus.k_in;
            end
         end
      end
   end

   // Zero-latency read mux; an index with no register reads as zero
   always_comb begin
      bus.k_out = '0;
      for (int i = 0; i < NUM_K; i++)
         if (int'(bus.rd_sel) == i) bus.k_out = k_reg[i];
   end

   assign bus.k_valid   = k_valid_q;
   assign bus.busy      = (state_q == LOAD);
   assign bus.commit    = commit_q;
   assign bus.err       = err_q;
   assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_const_reg_bank.sv
// Randomized and directed bench for const_reg_bank against a byte-queue reference model.
module tb_const_reg_bank;
   localparam int DATA_W = 8;
   localparam int BYTES  = 2;
   localparam int NUM_K  = 4;

   logic clk;
   logic reset;

   const_reg_bank_if #(.DATA_W(DATA_W), .BYTES(BYTES), .NUM_K(NUM_K)) bus ();

   const_reg_bank #(.DATA_W(DATA_W), .BYTES(BYTES), .NUM_K(NUM_K)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard
   int          n_checks = 0;
   int          n_errors = 0;
   logic [15:0] exp_q[$];
   logic [1:0]  exp_sel_q[$];

   // reference model: registers, valid flags, collected load bytes
   logic [15:0] m_reg [NUM_K];
   logic [3:0]  m_valid;
   logic        m_busy;
   logic        m_err;
   logic        m_commit;
   logic [1:0]  m_tgt;
   logic        m_ext;
   logic [7:0]  m_bytes[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < NUM_K; i++) m_reg[i] = '0;
      m_valid  = '0;
      m_busy   = 1'b0;
      m_err    = 1'b0;
      m_commit = 1'b0;
      m_tgt    = '0;
      m_ext    = 1'b0;
      m_bytes.delete();
      exp_q.delete();
      exp_sel_q.delete();
   endtask

   task automatic model_step(input logic ls, input logic [1:0] lsel, input logic lb,
                             input logic ll, input logic sx, input logic [7:0] kin,
                             input logic dwe, input logic [1:0] dsel, input logic db);
      logic        cm;
      int          n;
      logic [31:0] v;
      cm = 1'b0;
      if (ls) begin
         m_busy = 1'b1;
         m_tgt  = lsel;
         m_ext  = sx;
         m_err  = 1'b0;
         m_bytes.delete();
      end else if (lb) begin
         if (!m_busy) m_err = 1'b1;
         else begin
            if (m_bytes.size() < BYTES) m_bytes.push_back(kin);
            else m_err = 1'b1;
            if (ll) begin
               n = m_bytes.size();
               v = 32'h0;
               for (int i = 0; i < n; i++) v = v | (32'(m_bytes[i]) << (8 * i));
               if (m_ext && m_bytes[n-1][7]) v = v | (32'hFFFF_FFFF << (8 * n));
               m_reg[m_tgt]   = v[15:0];
               m_valid[m_tgt] = 1'b1;
               m_busy = 1'b0;
               m_bytes.delete();
               cm = 1'b1;
               exp_q.push_back(v[15:0]);
               exp_sel_q.push_back(m_tgt);
            end
         end
      end
      if (dwe && !(cm && dsel == m_tgt)) begin
         if (db) m_reg[dsel] = {kin, m_reg[dsel][7:0]};
         else    m_reg[dsel] = {m_reg[dsel][15:8], kin};
      end
      m_commit = cm;
   endtask

   // compare every observable output with the model; ends well before the next edge
   task automatic check_all(input string tag);
      logic [1:0]  s;
      logic [15:0] v;
      check({tag, ".k_valid"}, 32'(bus.k_valid), 32'(m_valid));
      check({tag, ".busy"}, 32'(bus.busy), 32'(m_busy));
      check({tag, ".state_dbg"}, 32'(bus.state_dbg), 32'(m_busy));
      check({tag, ".err"}, 32'(bus.err), 32'(m_err));
      check({tag, ".commit"}, 32'(bus.commit), 32'(m_commit));
      for (int i = 0; i < NUM_K; i++) begin
         bus.rd_sel = 2'(i);
         #1;
         check($sformatf("%s.k_out%0d", tag, i), 32'(bus.k_out), 32'(m_reg[i]));
      end
      if (m_commit) begin
         if (exp_q.size() == 0) check({tag, ".exp_q_empty"}, 32'(1), 32'(0));
         else begin
            s = exp_sel_q.pop_front();
            v = exp_q.pop_front();
            bus.rd_sel = s;
            #1;
            check({tag, ".commit_val"}, 32'(bus.k_out), 32'(v));
         end
      end
   endtask

   // one clock: drive, advance the model, take the edge, check
   task automatic cycle(input string tag, input logic ls, input logic [1:0] lsel,
                        input logic lb, input logic ll, input logic sx, input logic [7:0] kin,
                        input logic dwe, input logic [1:0] dsel, input logic db);
      bus.load_start = ls;
      bus.load_sel   = lsel;
      bus.load_byte  = lb;
      bus.load_last  = ll;
      bus.sext       = sx;
      bus.k_in       = kin;
      bus.dir_we     = dwe;
      bus.dir_sel    = dsel;
      bus.dir_byte   = db;
      model_step(ls, lsel, lb, ll, sx, kin, dwe, dsel, db);
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic t_start(input string tag, input logic [1:0] sel, input logic sx);
      cycle(tag, 1'b1, sel, 1'b0, 1'b0, sx, 8'h00, 1'b0, 2'd0, 1'b0);
   endtask

   task automatic t_byte(input string tag, input logic [7:0] kin, input logic last);
      cycle(tag, 1'b0, 2'd0, 1'b1, last, 1'b0, kin, 1'b0, 2'd0, 1'b0);
   endtask

   task automatic t_idle(input string tag);
      cycle(tag, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
   endtask

   task automatic read_reg(input logic [1:0] sel, output logic [15:0] v);
      bus.rd_sel = sel;
      #1;
      v = bus.k_out;
   endtask

   task automatic expect_reg(input string tag, input logic [1:0] sel, input logic [15:0] exp);
      logic [15:0] v;
      read_reg(sel, v);
      check(tag, 32'(v), 32'(exp));
   endtask

   initial begin
      logic [15:0] r;
      bus.k_in = '0; bus.load_start = 1'b0; bus.load_sel = '0; bus.load_byte = 1'b0;
      bus.load_last = 1'b0; bus.sext = 1'b0; bus.dir_we = 1'b0; bus.dir_sel = '0;
      bus.dir_byte = '0; bus.rd_sel = '0;
      m_reset();
      reset = 1'b1;
      #3;
      check_all("reset");
      #9 reset = 1'b0;

      // asynchronous reset in the middle of a load
      t_start("rst_mid.start", 2'd1, 1'b0);
      t_byte("rst_mid.byte", 8'h55, 1'b0);
      t_idle("rst_mid.gap");
      t_byte("rst_mid.last", 8'h66, 1'b1);
      t_start("rst_mid.start2", 2'd1, 1'b0);
      t_byte("rst_mid.byte2", 8'h77, 1'b0);
      reset = 1'b1;
      #1;
      m_reset();
      check("rst_mid.busy_async", 32'(bus.busy), 32'(0));
      check("rst_mid.kvalid_async", 32'(bus.k_valid), 32'(0));
      check_all("rst_mid");
      #2 reset = 1'b0;

      // sequential load, zero extension not needed
      t_start("seq2.start", 2'd2, 1'b0);
      t_byte("seq2.b0", 8'h34, 1'b0);
      t_byte("seq2.b1", 8'h12, 1'b1);
      expect_reg("seq2.reg2", 2'd2, 16'h1234);
      check("seq2.kvalid", 32'(bus.k_valid), 32'h4);
      check("seq2.commit_hi", 32'(bus.commit), 32'(1));
      t_idle("seq2.after");
      check("seq2.commit_lo", 32'(bus.commit), 32'(0));

      // single-byte loads with sign and zero extension
      t_start("ext.s1", 2'd1, 1'b1);
      t_byte("ext.s1b", 8'h85, 1'b1);
      expect_reg("ext.sext_neg", 2'd1, 16'hFF85);
      t_start("ext.z1", 2'd1, 1'b0);
      t_byte("ext.z1b", 8'h85, 1'b1);
      expect_reg("ext.zext", 2'd1, 16'h0085);
      t_start("ext.s2", 2'd1, 1'b1);
      t_byte("ext.s2b", 8'h05, 1'b1);
      expect_reg("ext.sext_pos", 2'd1, 16'h0005);

      // direct writes, alone and against a same-cycle commit
      t_start("dir.start", 2'd3, 1'b0);
      t_byte("dir.b0", 8'hEF, 1'b0);
      t_byte("dir.b1", 8'hBE, 1'b1);
      expect_reg("dir.beef", 2'd3, 16'hBEEF);
      cycle("dir.patch", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h12, 1'b1, 2'd3, 1'b1);
      expect_reg("dir.12ef", 2'd3, 16'h12EF);
      t_start("dir.race_start", 2'd3, 1'b0);
      t_byte("dir.race_b0", 8'h01, 1'b0);
      cycle("dir.race", 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 8'h02, 1'b1, 2'd3, 1'b0);
      expect_reg("dir.commit_wins", 2'd3, 16'h0201);
      t_start("dir.ind_start", 2'd3, 1'b0);
      cycle("dir.ind", 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 8'h9C, 1'b1, 2'd0, 1'b1);
      expect_reg("dir.ind_reg0", 2'd0, 16'h9C00);
      expect_reg("dir.ind_reg3", 2'd3, 16'h009C);

      // pointer overflow, commit of the existing shadow, err clearing and idle byte
      t_start("ovf.start", 2'd0, 1'b0);
      t_byte("ovf.b0", 8'h11, 1'b0);
      t_byte("ovf.b1", 8'h22, 1'b0);
      t_byte("ovf.b2", 8'h33, 1'b0);
      check("ovf.err_set", 32'(bus.err), 32'(1));
      t_byte("ovf.last", 8'h44, 1'b1);
      expect_reg("ovf.2211", 2'd0, 16'h2211);
      t_start("ovf.restart", 2'd1, 1'b0);
      check("ovf.err_clear", 32'(bus.err), 32'(0));
      t_byte("ovf.fin", 8'h07, 1'b1);
      t_byte("ovf.idle_byte", 8'h08, 1'b0);
      check("ovf.idle_err", 32'(bus.err), 32'(1));

      // abort by restart, then start and byte together
      t_start("abort.start", 2'd0, 1'b0);
      t_byte("abort.b0", 8'hAA, 1'b0);
      read_reg(2'd0, r);
      t_start("abort.restart", 2'd0, 1'b0);
      check("abort.no_commit", 32'(bus.commit), 32'(0));
      expect_reg("abort.unchanged", 2'd0, r);
      t_byte("abort.b1", 8'h01, 1'b0);
      t_byte("abort.b2", 8'h02, 1'b1);
      expect_reg("abort.0201", 2'd0, 16'h0201);
      t_start("sb.start", 2'd2, 1'b0);
      cycle("sb.both", 1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 8'hEE, 1'b0, 2'd0, 1'b0);
      t_byte("sb.b0", 8'h0D, 1'b0);
      t_byte("sb.b1", 8'h0C, 1'b1);
      expect_reg("sb.ptr0", 2'd2, 16'h0C0D);

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         cycle("rand",
               1'($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
               1'($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
